// File: rtl/async_fifo.sv
// async_fifo: single-clock FIFO using the dual-pointer Gray-code structure of
// the clock-crossing FIFO. Each side compares against the other side's Gray
// pointer after a SYNC_STAGES flop synchronizer. That makes full/empty
// conservative, with a fixed latency.
// rdata is first-word fall-through: it always shows the head-of-queue word.
// Optional macro ASYNC_FIFO_LEVEL_EN adds the wlevel/rlevel occupancy outputs.
module async_fifo #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wpush,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  wfull,
    input  logic                  rpull,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rempty
`ifdef ASYNC_FIFO_LEVEL_EN
    ,
    output logic [ADDR_WIDTH:0]   wlevel,
    output logic [ADDR_WIDTH:0]   rlevel
`endif
);

    localparam int MEMORY_DEPTH = 1 << ADDR_WIDTH;
    localparam int PW           = ADDR_WIDTH + 1;

    // A pointer is full when it matches the read pointer with its top two
    // Gray bits inverted. That is the Gray form of "one lap ahead".
    localparam logic [PW-1:0] FULL_MASK = {2'b11, {(PW-2){1'b0}}};

    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    logic [DATA_WIDTH-1:0] mem [MEMORY_DEPTH];

    logic [PW-1:0] wbin, wgray, wbin_next, wgray_next;
    logic [PW-1:0] rbin, rgray, rbin_next, rgray_next;
    logic          wfull_next, rempty_next;

    // Synchronizer chains. Stage 0 samples the opposite side's Gray pointer.
    logic [PW-1:0] wq_sync [SYNC_STAGES];
    logic [PW-1:0] rq_sync [SYNC_STAGES];
    logic [PW-1:0] wq_gray, rq_gray;

    assign wq_gray = wq_sync[SYNC_STAGES-1];
    assign rq_gray = rq_sync[SYNC_STAGES-1];

    // Write side: next pointer and full flag. Only wfull gates a push.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
        wbin_next  = wbin;
        if (wpush && !wfull)
            wbin_next = wbin + PW'(1);
        wgray_next = bin2gray(wbin_next);
        wfull_next = (wgray_next == (rq_gray ^ FULL_MASK));
    end

    // Read side: next pointer and empty flag. Only rempty gates a pop.
    always_comb begin
        rbin_next = rbin;
        if (rpull && !rempty)
            rbin_next = rbin + PW'(1);
        rgray_next  = bin2gray(rbin_next);
        rempty_next = (rgray_next == wq_gray);
    end

    // Write pointer and full flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
            wbin  <= '0;
            wgray <= '0;
            wfull <= 1'b0;
        end else begin
            wbin  <= wbin_next;
            wgray <= wgray_next;
            wfull <= wfull_next;
        end
    end

    // Read pointer and empty flag registers. rempty comes out of reset set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rbin   <= '0;
            rgray  <= '0;
            rempty <= 1'b1;
        end else begin
            rbin   <= rbin_next;
            rgray  <= rgray_next;
            rempty <= rempty_next;
        end
    end

    // Pointer synchronizers. Only Gray-coded pointers cross between the sides.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                wq_sync[i] <= '0;
                rq_sync[i] <= '0;
            end
        end else begin
            wq_sync[0] <= wgray;
            rq_sync[0] <= rgray;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                wq_sync[i] <= wq_sync[i-1];
                rq_sync[i] <= rq_sync[i-1];
            end
        end
    end

    // Storage write port.
    always_ff @(posedge clk) begin
        // NOTE: the memory array has no reset. Empty/full keep stale words from being observed, and a reset would block RAM inference.
        if (wpush && !wfull)
            mem[wbin[ADDR_WIDTH-1:0]] <= wdata;
    end

    // First-word fall-through read port.
    assign rdata = mem[rbin[ADDR_WIDTH-1:0]];

`ifdef ASYNC_FIFO_LEVEL_EN
    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--)
            b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    // Occupancy as each side sees it. It is conservative in the same way as the flags.
    assign wlevel = wbin - gray2bin(rq_gray);
    assign rlevel = gray2bin(wq_gray) - rbin;
`endif

endmodule

// File: tb/tb_async_fifo.sv
// Directed testbench for async_fifo. Each scenario task drives its own stimulus
// and checks against hand-derived expected values.
module tb_async_fifo;

    localparam int DW = 32;
    localparam int AW = 4;

    logic          clk;
    logic          rst_n;
    logic          wpush;
    logic [DW-1:0] wdata;
    logic          wfull;
    logic          rpull;
    logic [DW-1:0] rdata;
    logic          rempty;
`ifdef ASYNC_FIFO_LEVEL_EN
    logic [AW:0]   wlevel;
    logic [AW:0]   rlevel;
`endif

    int errors = 0;
    int checks = 0;

    async_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SYNC_STAGES(2)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .wpush  (wpush),
        .wdata  (wdata),
        .wfull  (wfull),
        .rpull  (rpull),
        .rdata  (rdata),
        .rempty (rempty)
`ifdef ASYNC_FIFO_LEVEL_EN
        ,
        .wlevel (wlevel),
        .rlevel (rlevel)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One rising edge, then settle 1ns past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        wpush = 1'b0;
        rpull = 1'b0;
        wdata = '0;
        #12;
        rst_n = 1'b0;
        #1;
        checks++;
        if (rempty !== 1'b1) begin
            errors++;
            $display("FAIL reset_rempty_async: got %b want 1", rempty);
        end
        checks++;
        if (wfull !== 1'b0) begin
            errors++;
            $display("FAIL reset_wfull_async: got %b want 0", wfull);
        end
        step();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++;
        if (rempty !== 1'b1 || wfull !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: rempty=%b wfull=%b want 1/0", rempty, wfull);
        end
    endtask

    task automatic test_single_word();
        wpush = 1'b1;
        wdata = 32'h2;
        step();
        wpush = 1'b0;
        for (int e = 0; e < 2; e++) begin
            checks++;
            if (rempty !== 1'b1) begin
                errors++;
                $display("FAIL single_rempty_early edge+%0d: got %b want 1", e, rempty);
            end
            step();
        end
        checks++;
        if (rempty !== 1'b1) begin
            errors++;
            $display("FAIL single_rempty_early edge+2: got %b want 1", rempty);
        end
        step();
        checks++;
        if (rempty !== 1'b0) begin
            errors++;
            $display("FAIL single_rempty_k3: got %b want 0", rempty);
        end
        checks++;
        if (rdata !== 32'h2) begin
            errors++;
            $display("FAIL single_rdata: got %h want 00000002", rdata);
        end
        rpull = 1'b1;
        step();
        rpull = 1'b0;
        checks++;
        if (rempty !== 1'b1) begin
            errors++;
            $display("FAIL single_rempty_after_pull: got %b want 1", rempty);
        end
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 16; i++) begin
            wpush = 1'b1;
            wdata = DW'(i);
            step();
            checks++;
            if (wfull !== (i == 15)) begin
                errors++;
                $display("FAIL fill_wfull push %0d: got %b want %b", i, wfull, i == 15);
            end
        end
        wdata = 32'hFF;
        step();
        wpush = 1'b0;
        checks++;
        if (wfull !== 1'b1) begin
            errors++;
            $display("FAIL fill_wfull_after_17th: got %b want 1", wfull);
        end
        step();
        step();
        checks++;
        if (rempty !== 1'b0) begin
            errors++;
            $display("FAIL fill_rempty: got %b want 0", rempty);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (rdata !== DW'(i)) begin
                errors++;
                $display("FAIL drain_rdata %0d: got %h want %h", i, rdata, DW'(i));
            end
            rpull = 1'b1;
            step();
            checks++;
            if (wfull !== (i < 3)) begin
                errors++;
                $display("FAIL drain_wfull pull %0d: got %b want %b", i, wfull, i < 3);
            end
            checks++;
            if (rempty !== (i == 15)) begin
                errors++;
                $display("FAIL drain_rempty pull %0d: got %b want %b", i, rempty, i == 15);
            end
        end
        rpull = 1'b0;
        for (int e = 0; e < 4; e++) step();
        checks++;
        if (rempty !== 1'b1 || wfull !== 1'b0) begin
            errors++;
            $display("FAIL drain_settled: rempty=%b wfull=%b want 1/0", rempty, wfull);
        end
    endtask

    task automatic test_trickle();
        int got;
        got = 0;
        rpull = 1'b1;
        for (int c = 0; c < 40; c++) begin
            wpush = (c % 2 == 0) && (c < 20);
            wdata = DW'(c / 2 + 2);
            if (rempty === 1'b0) begin
                checks++;
                if (rdata !== DW'(got + 2)) begin
                    errors++;
                    $display("FAIL trickle_rdata %0d: got %h want %h", got, rdata, DW'(got + 2));
                end
                got++;
            end
            step();
        end
        wpush = 1'b0;
        rpull = 1'b0;
        checks++;
        if (got != 10) begin
            errors++;
            $display("FAIL trickle_count: got %0d words want 10", got);
        end
        checks++;
        if (rempty !== 1'b1) begin
            errors++;
            $display("FAIL trickle_rempty_end: got %b want 1", rempty);
        end
    endtask

    task automatic test_wrap();
        int sent;
        int got;
        sent = 0;
        got  = 0;
        for (int c = 0; c < 300 && got < 40; c++) begin
            wpush = (sent < 40);
            wdata = 32'h100 + DW'(sent);
            rpull = 1'b1;
            if (rempty === 1'b0) begin
                checks++;
                if (rdata !== 32'h100 + DW'(got)) begin
                    errors++;
                    $display("FAIL wrap_rdata %0d: got %h want %h", got, rdata, 32'h100 + DW'(got));
                end
                got++;
            end
            if (wpush && wfull === 1'b0)
                sent++;
            step();
        end
        wpush = 1'b0;
        rpull = 1'b0;
        checks++;
        if (got != 40 || sent != 40) begin
            errors++;
            $display("FAIL wrap_count: got %0d sent %0d want 40/40", got, sent);
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 5; i++) begin
            wpush = 1'b1;
            wdata = 32'h50 + DW'(i);
            step();
        end
        wpush = 1'b0;
        for (int e = 0; e < 4; e++) step();
        checks++;
        if (rempty !== 1'b0 || rdata !== 32'h50) begin
            errors++;
            $display("FAIL midrst_preload: rempty=%b rdata=%h want 0/00000050", rempty, rdata);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (rempty !== 1'b1 || wfull !== 1'b0) begin
            errors++;
            $display("FAIL midrst_async: rempty=%b wfull=%b want 1/0", rempty, wfull);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++;
        if (rempty !== 1'b1) begin
            errors++;
            $display("FAIL midrst_after_release: rempty=%b want 1", rempty);
        end
        wpush = 1'b1;
        wdata = 32'hA;
        step();
        wpush = 1'b0;
        step();
        step();
        checks++;
        if (rempty !== 1'b1) begin
            errors++;
            $display("FAIL midrst_rempty_k2: got %b want 1", rempty);
        end
        step();
        checks++;
        if (rempty !== 1'b0 || rdata !== 32'hA) begin
            errors++;
            $display("FAIL midrst_readback: rempty=%b rdata=%h want 0/0000000a", rempty, rdata);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_fill_drain();
        test_trickle();
        test_wrap();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/async_fifo.md
Name: async_fifo

Overview:
- Single-clock FIFO built on the dual-pointer Gray-code architecture of the CPU's clock-crossing FIFO.
- Write and read pointers are each passed through a SYNC_STAGES flop synchronizer before the opposite side compares against them. Full/empty are therefore conservative and have fixed, predictable latency.
- Used as a drop-in buffer between CPU pipeline blocks, and as a same-clock stand-in for the dual-clock FIFO.

Parameters:
- DATA_WIDTH, 32, width of each stored word.
- ADDR_WIDTH, 4, log2 of the depth; pointers are ADDR_WIDTH+1 bits.
- MEMORY_DEPTH, 1<<ADDR_WIDTH, number of entries (derived; not overridable).
- SYNC_STAGES, 2, pointer synchronizer depth (>=1).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- wpush  input  1  write request.
- wdata  input  DATA_WIDTH  write data.
- wfull  output  1  FIFO full; registered.
- rpull  input  1  read request (pop).
- rdata  output  DATA_WIDTH  head-of-queue word; first-word fall-through.
- rempty  output  1  FIFO empty; registered.

Behaviour:
- Reset: on rst_n low, immediately and asynchronously:
  - binary and Gray pointers, and all synchronizer flops, go to 0;
  - rempty=1, wfull=0.
  - Memory is not reset.
- Write:
  - On posedge clk with wpush=1 and wfull=0: mem[wbin[ADDR_WIDTH-1:0]] <= wdata and wbin increments.
  - wpush while wfull=1 is ignored; no pointer or memory change.
- Read:
  - rdata = mem[rbin[ADDR_WIDTH-1:0]] combinationally.
  - On posedge with rpull=1 and rempty=0, rbin increments.
  - rpull while rempty=1 is ignored.
  - rdata is don't-care while rempty=1.
- Gray pointers: gray = bin ^ (bin>>1), registered alongside bin. Only the Gray pointers cross the synchronizers.
- Empty: rempty <= (next read Gray == synchronized write Gray).
  - A write at edge k clears rempty at edge k+SYNC_STAGES+1 (edge k+3 by default).
  - A read that removes the last word sets rempty at that same edge.
- Full: wfull <= (next write Gray == synchronized read Gray with its top two bits inverted).
  - The push that stores the 16th word sets wfull at that same edge.
  - A read at edge k clears wfull at edge k+SYNC_STAGES+1.
- Wrap-around: ADDR_WIDTH+1-bit pointers wrap naturally. The extra MSB distinguishes full from empty, and data order is preserved across wrap.
- Simultaneous push and pull: both are accepted in the same cycle when their respective flags allow. Each side uses only its own flag.
- Ordering: strict FIFO; no word is lost or duplicated.

Optional Feature:
- Macro ASYNC_FIFO_LEVEL_EN.
- When defined, two extra outputs are added, each ADDR_WIDTH+1 bits:
  - wlevel = wbin - (synchronized read pointer converted to binary);
  - rlevel = (synchronized write pointer converted to binary) - rbin.
- Both levels reset to 0 and are conservative in the same way as the flags.
- When the macro is undefined, these ports and their Gray-to-binary logic do not exist. All other behaviour is identical.

Test Plan:
- Reset: hold rst_n=0 mid-clock -> rempty=1 and wfull=0 immediately, before any clock edge.
- Single word: push 0x2 at edge k -> rempty falls at edge k+3 and rdata=0x2; pull once -> rempty=1 after that edge.
- Fill/drain: 16 pushes of 0..15 with no pulls -> wfull=1 at the 16th push edge; a 17th push of 0xFF is ignored; 16 pulls return 0..15 in order; wfull clears 3 edges after the first pull.
- Trickle: rpull held at 1, push i+2 every other cycle for i=0..9 -> rdata sequence 2..11 with no duplicates or underflow; rempty=1 at the end.
- Wrap: push 40 sequential words while pulling whenever rempty=0 -> all 40 are received in order across both pointer wraps.
- Mid-operation reset: with 5 words stored, pulse rst_n low -> rempty=1 at once; a subsequent push of 0xA reads back as 0xA.
